// File: rtl/mipi_tx_fifo_pkg.sv
// Shared definitions for the MIPI TX line FIFO read side.
// Holds the RAM and pointer widths, the read-controller state type and the
// default line length (1920 px RGB888 packs into 1440 32-bit words).
package mipi_tx_fifo_pkg;

   localparam int ADDR_W             = 10;
   localparam int PTR_W              = 11;
   localparam int DATA_W             = 32;
   localparam int LINE_WORDS_DEFAULT = 1440;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } rd_state_t;

endpackage

// File: rtl/mipi_tx_rd_skid.sv
// Two-entry skid buffer between the FIFO RAM read port and the TX stream.
// Entry 0 is the head and drives the outputs directly, so the head word and
// its markers stay put until popped. A push and a pop in the same cycle keep
// the occupancy unchanged and preserve order.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   push, push_data/sol/eol  word returning from the RAM with its markers
//   pop                  head consumed this cycle (ignored when empty)
//   valid, data, sol, eol    head entry
//   count                occupancy 0..2
module mipi_tx_rd_skid
   import mipi_tx_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_sol,
   input  logic              push_eol,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              sol,
   output logic              eol,
   output logic [1:0]        count
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sol;
      logic              eol;
   } entry_t;

   entry_t e0;
   entry_t e1;
   entry_t din;
   logic   pop_ok;

   assign din    = {push_data, push_sol, push_eol};
   assign pop_ok = pop && (count != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (count == 2'd0) begin
                  e0    <= din;
                  count <= 2'd1;
               end else if (count == 2'd1) begin
                  e1    <= din;
                  count <= 2'd2;
               end
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; new word lands behind whatever remains
               if (count == 2'd1) begin
                  e0 <= din;
               end else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid = (count != 2'd0);
   assign data  = e0.data;
   assign sol   = e0.sol;
   assign eol   = e0.eol;

endmodule

// File: rtl/mipi_tx_fifo_rd_ctrl.sv
// Read-side controller for the 1024x32 MIPI TX line FIFO (clkr domain).
// Waits for START_THRESH words, then reads one line of LINE_WORDS words out
// of the RAM (1-cycle read latency) into a 2-entry skid buffer and presents
// them as a valid/ready stream with start/end-of-line markers, followed by
// GAP_CYCLES idle cycles.
// Optional build macro MIPI_TX_RD_UNDERFLOW_EN adds underflow_cnt (saturating)
// and the sticky underflow_flag.
// Ports:
//   clkr, rstr        clock, synchronous active-high reset
//   wr_ptr / rd_ptr   binary FIFO pointers (wr_ptr already in clkr)
//   ar, cer, qr       RAM read port
//   tx_*              stream to the packetiser
//   busy, level       not-IDLE indication, fill level
//
// state  | meaning
// IDLE   | waiting for level >= START_THRESH
// STREAM | issuing reads and delivering the current line
// GAP    | inter-line idle time after the last word is accepted
module mipi_tx_fifo_rd_ctrl
   import mipi_tx_fifo_pkg::*;
#(
   parameter int LINE_WORDS   = LINE_WORDS_DEFAULT,
   parameter int START_THRESH = 256,
   parameter int GAP_CYCLES   = 16
) (
   input  logic              clkr,
   input  logic              rstr,
   input  logic [PTR_W-1:0]  wr_ptr,
   output logic [PTR_W-1:0]  rd_ptr,
   output logic [ADDR_W-1:0] ar,
   output logic              cer,
   input  logic [DATA_W-1:0] qr,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_sol,
   output logic              tx_eol,
   output logic              busy,
   output logic [PTR_W-1:0]  level
`ifdef MIPI_TX_RD_UNDERFLOW_EN
   ,
   output logic [15:0]       underflow_cnt,
   output logic              underflow_flag
`endif
);

   localparam logic [PTR_W-1:0] LW     = PTR_W'(LINE_WORDS);
   localparam logic [PTR_W-1:0] LW_M1  = PTR_W'(LINE_WORDS - 1);
   localparam logic [PTR_W-1:0] THRESH = PTR_W'(START_THRESH);
   localparam logic [7:0]       GAP_M1 = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   rd_state_t        state;
   logic [PTR_W-1:0] issued;
   logic [7:0]       gap_cnt;
   logic             inflight;
   logic             inflight_sol;
   logic             inflight_eol;
   logic [1:0]       sk_count;
   logic             pop;
   logic [2:0]       occ;

   assign level = wr_ptr - rd_ptr;
   assign busy  = (state != IDLE);
   assign pop   = tx_valid && tx_ready;

   // Occupancy the buffer will have once this cycle's capture and consume
   // settle; counting the pop is what lets one read per cycle keep up.
   assign occ = {1'b0, sk_count} + {2'b00, inflight} - {2'b00, pop};

   assign cer = (state == STREAM) && (issued < LW) && (level != '0) && (occ < 3'd2);
   assign ar  = rd_ptr[ADDR_W-1:0];

   always_ff @(posedge clkr) begin
      if (rstr) begin
         state        <= IDLE;
         rd_ptr       <= '0;
         issued       <= '0;
         gap_cnt      <= '0;
         inflight     <= 1'b0;
         inflight_sol <= 1'b0;
         inflight_eol <= 1'b0;
      end else begin
         // markers are decided at issue time and ride along with the read
         inflight     <= cer;
         inflight_sol <= cer && (issued == '0);
         inflight_eol <= cer && (issued == LW_M1);
         if (cer) begin
            rd_ptr <= rd_ptr + 1'b1;
            issued <= issued + 1'b1;
         end
         case (state)
            IDLE: begin
               if (level >= THRESH) begin
                  state  <= STREAM;
                  issued <= '0;
               end
            end
            STREAM: begin
               if (pop && tx_eol) begin
                  if (GAP_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= GAP_M1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mipi_tx_rd_skid u_skid (
      .clk       (clkr),
      .rst       (rstr),
      .push      (inflight),
      .push_data (qr),
      .push_sol  (inflight_sol),
      .push_eol  (inflight_eol),
      .pop       (pop),
      .valid     (tx_valid),
      .data      (tx_data),
      .sol       (tx_sol),
      .eol       (tx_eol),
      .count     (sk_count)
   );

`ifdef MIPI_TX_RD_UNDERFLOW_EN
   logic uf_hit;

   assign uf_hit = (state == STREAM) && (issued < LW) && (level == '0);

   always_ff @(posedge clkr) begin
      if (rstr) begin
         underflow_cnt  <= '0;
         underflow_flag <= 1'b0;
      end else if (uf_hit) begin
         if (underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
         end
         underflow_flag <= 1'b1;
      end
   end
`endif

endmodule
